// File: rtl/rgmii_pkg.sv
// Shared types, framing constants and the byte-wise CRC-32 step for the RGMII
// transmit path.
package rgmii_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRE   = 3'd1,
    ST_SFD   = 3'd2,
    ST_DATA  = 3'd3,
    ST_PAD   = 3'd4,
    ST_FCS   = 3'd5,
    ST_IFG   = 3'd6,
    ST_DRAIN = 3'd7
  } state_e;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [15:0] PRE_LEN       = 16'd7;
  localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY      = 32'hEDB8_8320;

  // Reflected CRC-32 over one byte, LSB first; the loop unrolls into 8 steps.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h00_0000, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ({1'b0, c[31:1]} ^ CRC_POLY) : {1'b0, c[31:1]};
    end
    return c;
  endfunction

endpackage

// File: rtl/rgmii_tx_ctrl.sv
// RGMII transmit framing: preamble/SFD, zero padding, FCS and inter-frame gap,
// presented as registered rising/falling nibble pairs for the DDR output cells.
module rgmii_tx_ctrl
  import rgmii_pkg::*;
#(
  parameter int IFG_BYTES = 12,
  parameter int MIN_BYTES = 60,
  parameter bit PAD_EN    = 1'b1
) (
  input  logic        SCLK,
  input  logic        RST,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  input  logic        s_last,
  input  logic        s_err,
  output logic        s_ready,
  output logic [3:0]  txd_d0,
  output logic [3:0]  txd_d1,
  output logic        txctl_d0,
  output logic        txctl_d1,
  output logic        busy,
  output logic [15:0] frame_cnt,
  output logic [7:0]  underrun_cnt
);

  localparam logic [15:0] IFG_W = 16'(IFG_BYTES);
  localparam logic [15:0] MIN_W = 16'(MIN_BYTES);

  state_e      state_q, state_d;
  logic [7:0]  data_q, data_d;
  logic        en_q, en_d;
  logic        er_q, er_d;
  logic [31:0] crc_q, crc_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] ifg_q, ifg_d;
  logic [15:0] frame_q, frame_d;
  logic [7:0]  und_q, und_d;
  logic [31:0] fcs_word_s;
  logic [7:0]  fcs_byte_s;

  assign fcs_word_s = ~crc_q;
  assign fcs_byte_s = fcs_word_s[{cnt_q[1:0], 3'b000} +: 8];

  // State, output symbol and counter registers.
  always_ff @(posedge SCLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      data_q  <= 8'h00;
      en_q    <= 1'b0;
      er_q    <= 1'b0;
      crc_q   <= 32'h0000_0000;
      cnt_q   <= 16'd0;
      ifg_q   <= 16'd0;
      frame_q <= 16'd0;
      und_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      en_q    <= en_d;
      er_q    <= er_d;
      crc_q   <= crc_d;
      cnt_q   <= cnt_d;
      ifg_q   <= ifg_d;
      frame_q <= frame_d;
      und_q   <= und_d;
    end
  end

  // Next-state and next-symbol decode.
  always_comb begin
    state_d = state_q;
    data_d  = 8'h00;
    en_d    = 1'b0;
    er_d    = 1'b0;
    crc_d   = crc_q;
    cnt_d   = cnt_q;
    ifg_d   = ifg_q;
    frame_d = frame_q;
    und_d   = und_q;
    case (state_q)
      ST_IDLE: begin
        if (s_valid) begin
          data_d  = PREAMBLE_BYTE;
          en_d    = 1'b1;
          cnt_d   = 16'd1;
          state_d = ST_PRE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PRE: begin
        data_d  = PREAMBLE_BYTE;
        en_d    = 1'b1;
        cnt_d   = cnt_q + 16'd1;
        state_d = (cnt_q + 16'd1 >= PRE_LEN) ? ST_SFD : ST_PRE;
      end
      ST_SFD: begin
        data_d  = SFD_BYTE;
        en_d    = 1'b1;
        crc_d   = CRC_INIT;
        cnt_d   = 16'd0;
        state_d = ST_DATA;
      end
      ST_DATA: begin
        if (s_valid) begin
          data_d = s_data;
          en_d   = 1'b1;
          er_d   = s_err;
          crc_d  = crc32_byte(crc_q, s_data);
          cnt_d  = cnt_q + 16'd1;
          if (s_last && PAD_EN && (cnt_q + 16'd1 < MIN_W)) begin
            state_d = ST_PAD;
          end else if (s_last) begin
            cnt_d   = 16'd0;
            state_d = ST_FCS;
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          // Underrun: poison the frame with a tx_er byte and discard the rest.
          en_d    = 1'b1;
          er_d    = 1'b1;
          und_d   = (und_q == 8'hFF) ? und_q : und_q + 8'd1;
          ifg_d   = 16'd0;
          state_d = ST_DRAIN;
        end
      end
      ST_PAD: begin
        en_d  = 1'b1;
        crc_d = crc32_byte(crc_q, 8'h00);
        if (cnt_q + 16'd1 >= MIN_W) begin
          cnt_d   = 16'd0;
          state_d = ST_FCS;
        end else begin
          cnt_d   = cnt_q + 16'd1;
          state_d = ST_PAD;
        end
      end
      ST_FCS: begin
        data_d = fcs_byte_s;
        en_d   = 1'b1;
        cnt_d  = cnt_q + 16'd1;
        if (cnt_q[1:0] == 2'd3) begin
          frame_d = frame_q + 16'd1;
          ifg_d   = 16'd0;
          state_d = ST_IFG;
        end else begin
          state_d = ST_FCS;
        end
      end
      ST_IFG: begin
        ifg_d   = ifg_q + 16'd1;
        state_d = (ifg_q + 16'd1 >= IFG_W) ? ST_IDLE : ST_IFG;
      end
      ST_DRAIN: begin
        // The gap already elapses while the tail of the aborted frame is discarded.
        ifg_d = (ifg_q < IFG_W) ? ifg_q + 16'd1 : ifg_q;
        if (s_valid && s_last) begin
          state_d = (ifg_q + 16'd1 >= IFG_W) ? ST_IDLE : ST_IFG;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign s_ready      = (state_q == ST_DATA) || (state_q == ST_DRAIN);
  assign busy         = (state_q != ST_IDLE);
  assign txd_d0       = data_q[3:0];
  assign txd_d1       = data_q[7:4];
  assign txctl_d0     = en_q;
  assign txctl_d1     = en_q ^ er_q;
  assign frame_cnt    = frame_q;
  assign underrun_cnt = und_q;

endmodule

// File: tb/tb_rgmii_tx_ctrl.sv
// Scoreboard bench for rgmii_tx_ctrl: a PAD_EN=0 and a PAD_EN=1 instance share
// stimulus through a select, and a negedge monitor checks every output cycle.
module tb_rgmii_tx_ctrl;

  logic        SCLK = 1'b0;
  logic        RST  = 1'b1;
  logic [7:0]  s_data = 8'h00;
  logic        s_valid = 1'b0, s_last = 1'b0, s_err = 1'b0;
  logic        sel = 1'b0;
  logic        skip = 1'b1;

  logic        rdy0, rdy1, busy0, busy1, c00, c01, c10, c11;
  logic [3:0]  d00, d01, d10, d11;
  logic [15:0] fc0, fc1;
  logic [7:0]  uc0, uc1;

  logic        m_rdy, m_busy, m_c0, m_c1;
  logic [3:0]  m_d0, m_d1;
  logic [15:0] m_fc;
  logic [7:0]  m_uc;

  logic [8:0]  exp_q[$];
  int          len_q[$];
  int          gap_q[$];
  logic [7:0]  frm[$];
  int          nchk = 0;
  int          nerr = 0;

  always #4 SCLK = ~SCLK;

  rgmii_tx_ctrl #(.IFG_BYTES(12), .MIN_BYTES(60), .PAD_EN(1'b0)) dut0 (
    .SCLK(SCLK), .RST(RST), .s_data(s_data), .s_valid(s_valid & ~sel), .s_last(s_last),
    .s_err(s_err), .s_ready(rdy0), .txd_d0(d00), .txd_d1(d01), .txctl_d0(c00),
    .txctl_d1(c01), .busy(busy0), .frame_cnt(fc0), .underrun_cnt(uc0));

  rgmii_tx_ctrl #(.IFG_BYTES(12), .MIN_BYTES(60), .PAD_EN(1'b1)) dut1 (
    .SCLK(SCLK), .RST(RST), .s_data(s_data), .s_valid(s_valid & sel), .s_last(s_last),
    .s_err(s_err), .s_ready(rdy1), .txd_d0(d10), .txd_d1(d11), .txctl_d0(c10),
    .txctl_d1(c11), .busy(busy1), .frame_cnt(fc1), .underrun_cnt(uc1));

  assign m_rdy  = sel ? rdy1  : rdy0;
  assign m_busy = sel ? busy1 : busy0;
  assign m_c0   = sel ? c10   : c00;
  assign m_c1   = sel ? c11   : c01;
  assign m_d0   = sel ? d10   : d00;
  assign m_d1   = sel ? d11   : d01;
  assign m_fc   = sel ? fc1   : fc0;
  assign m_uc   = sel ? uc1   : uc0;

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    nchk++;
    if (!ok) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Bit-serial reference CRC (reflected, LSB first).
  function automatic logic [31:0] ref_crc(input logic [7:0] b[$]);
    logic [31:0] c;
    logic        fb;
    c = 32'hFFFF_FFFF;
    foreach (b[k]) begin
      for (int j = 0; j < 8; j++) begin
        fb = c[0] ^ b[k][j];
        c  = {1'b0, c[31:1]} ^ (fb ? 32'hEDB8_8320 : 32'h0000_0000);
      end
    end
    return c;
  endfunction

  task automatic send_frame(input int err_i, input int und_i, input bit keep, input bit chk_lat,
                            input int gap_exp, input bit push, input bit fix,
                            input logic [31:0] fix_fcs);
    logic [7:0]  body[$];
    logic [31:0] fcs;
    int          n, i, waits;
    bit          acc, und_done;
    n = frm.size();
    if (push) begin
      for (int k = 0; k < 7; k++) exp_q.push_back({1'b1, 8'h55});
      exp_q.push_back({1'b1, 8'hD5});
      if (und_i >= 0) begin
        for (int k = 0; k < und_i; k++) exp_q.push_back({(k == err_i) ? 1'b0 : 1'b1, frm[k]});
        exp_q.push_back({1'b0, 8'h00});
        len_q.push_back(8 + und_i + 1);
      end else begin
        body = frm;
        while (sel && body.size() < 60) body.push_back(8'h00);
        for (int k = 0; k < body.size(); k++) exp_q.push_back({(k == err_i) ? 1'b0 : 1'b1, body[k]});
        fcs = fix ? fix_fcs : ~ref_crc(body);
        for (int k = 0; k < 4; k++) exp_q.push_back({1'b1, fcs[8*k +: 8]});
        len_q.push_back(8 + body.size() + 4);
      end
      gap_q.push_back(gap_exp);
    end
    i = 0; waits = 0; und_done = 1'b0;
    while (i < n) begin
      if (i == und_i && !und_done) begin
        s_valid = 1'b0;
        und_done = 1'b1;
        @(posedge SCLK); #1;
      end else begin
        s_valid = 1'b1;
        s_data  = frm[i];
        s_last  = (i == n - 1);
        s_err   = (i == err_i);
        @(negedge SCLK);
        acc = m_rdy;
        @(posedge SCLK); #1;
        if (acc) begin
          i++;
        end else begin
          waits++;
          if (chk_lat && i == 0 && waits == 1) chk(m_c0 == 1'b1, "preamble_next_cycle", int'(m_c0), 1);
          if (waits > 500) begin
            chk(1'b0, "ready_timeout", waits, 500);
            i = n;
          end
        end
      end
    end
    if (chk_lat) chk(waits == 8, "ready_latency", waits, 8);
    s_last = 1'b0;
    s_err  = 1'b0;
    if (!keep) s_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int k = 0; k < 400 && !done; k++) begin
      @(posedge SCLK); #1;
      done = !m_busy;
    end
    chk(done, "idle_timeout", int'(m_busy), 0);
  endtask

  // Monitor: scoreboard pops on every tx_en cycle, idle cycles must be all-zero.
  initial begin
    logic [8:0] e;
    bit  prev_en;
    int  gap_cnt, blen, g, l;
    prev_en = 1'b0; gap_cnt = 0; blen = 0;
    forever begin
      @(negedge SCLK);
      if (skip) begin
        prev_en = m_c0; gap_cnt = 0; blen = 0;
      end else if (m_c0) begin
        if (!prev_en) begin
          blen = 0;
          if (gap_q.size() == 0) chk(1'b0, "unexpected_burst", gap_cnt, 0);
          else begin
            g = gap_q.pop_front();
            if (g >= 0) chk(gap_cnt == g, "ifg_gap", gap_cnt, g);
          end
        end
        if (exp_q.size() == 0) chk(1'b0, "unexpected_byte", int'({m_c1, m_d1, m_d0}), 0);
        else begin
          e = exp_q.pop_front();
          chk({m_c1, m_d1, m_d0} == e, "tx_byte", int'({m_c1, m_d1, m_d0}), int'(e));
        end
        blen++;
        prev_en = 1'b1;
      end else begin
        if (prev_en) begin
          if (len_q.size() == 0) chk(1'b0, "unexpected_burst_end", blen, 0);
          else begin
            l = len_q.pop_front();
            chk(blen == l, "en_length", blen, l);
          end
          gap_cnt = 0;
        end
        chk({m_c1, m_d1, m_d0} == 9'h000, "idle_symbol", int'({m_c1, m_d1, m_d0}), 0);
        gap_cnt++;
        prev_en = 1'b0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge SCLK);
    #1 RST = 1'b0;
    skip = 1'b0;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #0;
      chk({m_d1, m_d0, m_c0, m_c1} == 10'h000, "reset_outputs", int'({m_d1, m_d0, m_c0, m_c1}), 0);
      chk({m_rdy, m_busy} == 2'b00, "reset_ready_busy", int'({m_rdy, m_busy}), 0);
      chk({m_fc, m_uc} == 24'h0, "reset_counters", int'({m_fc, m_uc}), 0);
    end

    // PAD_EN=0: "123456789" with known FCS, then a back-to-back frame with s_valid held.
    sel = 1'b0;
    frm = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    send_frame(-1, -1, 1'b1, 1'b1, -1, 1'b1, 1'b1, 32'hCBF4_3926);
    frm = '{8'h41, 8'h42, 8'h43};
    send_frame(-1, -1, 1'b0, 1'b0, 12, 1'b1, 1'b0, 32'h0);
    wait_idle();
    chk(m_fc == 16'd2, "frame_cnt_nopad", int'(m_fc), 2);

    // PAD_EN=1: 14-byte padded frame, back-to-back 64-byte frame with s_err on byte 5.
    sel = 1'b1;
    frm.delete();
    for (int k = 0; k < 14; k++) frm.push_back(8'(k * 7 + 1));
    send_frame(-1, -1, 1'b1, 1'b1, -1, 1'b1, 1'b0, 32'h0);
    frm.delete();
    for (int k = 0; k < 64; k++) frm.push_back(8'(k) ^ 8'hA5);
    send_frame(5, -1, 1'b0, 1'b0, 12, 1'b1, 1'b0, 32'h0);
    wait_idle();
    chk(m_fc == 16'd2, "frame_cnt_pad", int'(m_fc), 2);

    // Underrun after 6 bytes; tail drained with en=0.
    frm.delete();
    for (int k = 0; k < 20; k++) frm.push_back(8'(8'h10 + k));
    send_frame(-1, 6, 1'b0, 1'b1, -1, 1'b1, 1'b0, 32'h0);
    wait_idle();
    chk(m_uc == 8'd1, "underrun_cnt", int'(m_uc), 1);
    chk(m_fc == 16'd2, "frame_cnt_after_underrun", int'(m_fc), 2);

    // Reset while padding, then a fresh frame straight from IDLE.
    skip = 1'b1;
    frm.delete();
    for (int k = 0; k < 10; k++) frm.push_back(8'(8'hC0 + k));
    send_frame(-1, -1, 1'b0, 1'b1, -1, 1'b0, 1'b0, 32'h0);
    repeat (5) @(posedge SCLK);
    #1 RST = 1'b1;
    @(posedge SCLK); #1 RST = 1'b0;
    chk({m_d1, m_d0, m_c0, m_c1} == 10'h000, "rst_pad_outputs", int'({m_d1, m_d0, m_c0, m_c1}), 0);
    chk({m_rdy, m_busy} == 2'b00, "rst_pad_ready_busy", int'({m_rdy, m_busy}), 0);
    chk({m_fc, m_uc} == 24'h0, "rst_pad_counters", int'({m_fc, m_uc}), 0);
    @(posedge SCLK); #1 skip = 1'b0;
    frm = '{8'hDE, 8'hAD, 8'hBE};
    send_frame(-1, -1, 1'b0, 1'b1, -1, 1'b1, 1'b0, 32'h0);
    wait_idle();
    chk(m_fc == 16'd1, "frame_cnt_after_reset", int'(m_fc), 1);

    repeat (3) @(posedge SCLK);
    chk(exp_q.size() == 0, "scoreboard_empty", exp_q.size(), 0);
    chk(len_q.size() == 0, "bursts_seen", len_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/rgmii_tx_ctrl.md
# rgmii_tx_ctrl

Transmit-side framing controller for the RGMII output path. Accepts a byte stream from the MAC, adds preamble/SFD, zero-pads short frames, appends the Ethernet FCS and enforces the inter-frame gap. Emits registered rising/falling-edge nibble pairs that feed five ODDRX1F DDR output cells: four on TXD and one on TX_CTL.

## Interface
Parameters:
- IFG_BYTES, 12, idle byte-times inserted after every frame; minimum 1.
- MIN_BYTES, 60, data+pad length before FCS when padding is enabled.
- PAD_EN, 1, 1 = zero-pad frames shorter than MIN_BYTES.

Ports:
- SCLK  in  1  byte clock (125 MHz); one byte per cycle.
- RST  in  1  synchronous, active-high reset.
- s_data  in  8  frame byte, destination MAC first, no FCS.
- s_valid  in  1  s_data valid.
- s_last  in  1  final byte of frame.
- s_err  in  1  mark this byte with tx_er.
- s_ready  out  1  byte accepted when s_valid && s_ready.
- txd_d0  out  4  rising-edge nibble, byte[3:0].
- txd_d1  out  4  falling-edge nibble, byte[7:4].
- txctl_d0  out  1  tx_en.
- txctl_d1  out  1  tx_en XOR tx_er.
- busy  out  1  state != IDLE.
- frame_cnt  out  16  completed frames, wraps.
- underrun_cnt  out  8  aborted frames, saturates at 255.

## Operation
- States: IDLE, PRE, SFD, DATA, PAD, FCS, IFG, DRAIN.
- Output byte register: every cycle it loads {data, en, er} as chosen by the current state. Idle symbol is data 0x00, en=0, er=0.
- IDLE: loads idle.
  - If s_valid=1: load first 0x55 and go to PRE.
- PRE: loads 0x55 until 7 preamble bytes in total have been loaded, then go to SFD.
- SFD: loads 0xD5; CRC initialised to 0xFFFFFFFF; byte counter cleared; go to DATA.
- DATA: s_ready=1.
  - If s_valid=1: load s_data with en=1 and er=s_err; update CRC; increment counter.
    - On s_last: if PAD_EN and count+1 < MIN_BYTES, go to PAD; else go to FCS.
  - If s_valid=0 (underrun): load 0x00 with en=1, er=1; increment underrun_cnt; go to DRAIN.
- PAD: loads 0x00 with en=1, feeding the CRC, until count == MIN_BYTES; then go to FCS.
- FCS: loads ~crc, bytes [7:0], [15:8], [23:16], [31:24] on 4 consecutive cycles with en=1; then go to IFG and increment frame_cnt.
- DRAIN: loads idle; s_ready=1; discards bytes until s_last is accepted.
  - IFG counting runs concurrently. Exit to IFG, with the remaining count, once the drain is complete.
- IFG: loads idle for IFG_BYTES cycles in total, counted from the first idle cycle after the last en=1 byte; then go to IDLE.
- CRC: IEEE 802.3 reflected CRC-32, polynomial 0xEDB88320, computed byte-wise LSB first.
- s_err affects only the byte it accompanies; the frame continues.
- s_ready=0 in every state except DATA and DRAIN.
- Reset, at any time including mid-frame: next cycle state=IDLE and outputs idle (txd_d0=txd_d1=0, txctl_d0=txctl_d1=0); s_ready=0; busy=0; CRC, byte counter, IFG counter, frame_cnt and underrun_cnt cleared.
  - A frame cut short by reset is not counted.
  - The IFG is considered satisfied after reset.

## Timing
- All outputs are registered, except s_ready and busy, which decode the state register.
- s_valid=1 in IDLE in cycle 0 produces:
  - 0x55 on the outputs in cycles 1–7;
  - 0xD5 in cycle 8;
  - s_ready=1 from cycle 8;
  - a byte accepted in cycle n appears on the outputs in cycle n+1.
- Last data/pad byte on the outputs in cycle m: FCS in cycles m+1..m+4, idle in cycles m+5..m+4+IFG_BYTES. The earliest next preamble is at m+5+IFG_BYTES.
- s_valid held in IDLE/IFG is not consumed; the new preamble starts from IDLE.
- Pin-level latency adds 3 SCLK cycles for the ODDRX1F pipeline, identical on all five lanes, so no skew compensation is needed.

## Structure
- Package rgmii_pkg:
  - state enum;
  - constants PREAMBLE_BYTE 0x55, SFD_BYTE 0xD5, CRC_INIT, CRC_POLY;
  - function crc32_byte(crc, byte), combinational, 8 unrolled steps.
- Sub-module: none. The ODDRX1F instances live in the parent rgmii_tx wrapper.

## Test plan
- PAD_EN=0, payload ASCII "123456789":
  - outputs show 7×0x55, 0xD5, payload, then FCS bytes 26 39 F4 CB;
  - then 12 idle cycles; frame_cnt=1.
- PAD_EN=1, 14-byte frame: 46 bytes of 0x00 pad follow, then 4 FCS bytes; en=1 for exactly 8+60+4=72 cycles.
- Back-to-back frames with s_valid held high: the gap between the last FCS byte and the next 0x55 is exactly 12 idle cycles.
- s_valid dropped mid-frame:
  - one cycle with txctl_d0=1, txctl_d1=0;
  - remaining bytes drained with s_ready=1 and en=0;
  - underrun_cnt=1, frame_cnt unchanged.
- s_err on byte 5: that output cycle has txctl_d1=0 while txctl_d0=1; all other bytes and the FCS are unchanged.
- RST asserted during PAD: the next cycle is idle with s_ready=0 and counters 0; a fresh frame then starts preamble 1 cycle after s_valid.
